// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode: compacts sparse fetch lanes at the tail and
// presents the oldest DEC_W entries with a variable-size pop. Define INSTQ_PC_EN to carry per-entry PCs.
module inst_queue #(
    parameter int INST_W  = 32,
    parameter int FETCH_W = 8,
    parameter int DEC_W   = 4,
    parameter int DEPTH   = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush_i,
    input  logic [FETCH_W*INST_W-1:0]        fetch_inst_i,
    input  logic [FETCH_W-1:0]               fetch_vld_i,
    output logic                             fetch_rdy_o,
`ifdef INSTQ_PC_EN
    input  logic [63:0]                      fetch_pc_i,
    output logic [DEC_W*64-1:0]              dec_pc_o,
`endif
    output logic [DEC_W*INST_W-1:0]          dec_inst_o,
    output logic [DEC_W-1:0]                 dec_vld_o,
    input  logic [$clog2(DEC_W+1)-1:0]       dec_take_i,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int OFF_W = $clog2(FETCH_W+1);

    logic [INST_W-1:0] mem [DEPTH];
`ifdef INSTQ_PC_EN
    logic [63:0]       pc_mem [DEPTH];
`endif

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] take_ext, ntake, push_cnt;
    logic [OFF_W-1:0] lane_off [FETCH_W];
    logic [OFF_W-1:0] npush;
    logic             push_en;

    // lane_off[k] is the number of valid lanes below k: the compacted slot offset for lane k
    always_comb begin
        npush = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            lane_off[k] = npush;
            npush       = npush + OFF_W'(fetch_vld_i[k]);
        end
    end

    assign fetch_rdy_o = (count_reg <= CNT_W'(DEPTH - FETCH_W));
    assign push_en     = fetch_rdy_o & (|fetch_vld_i);
    assign take_ext    = CNT_W'(dec_take_i);

    always_comb begin
        ntake      = (take_ext > count_reg) ? count_reg : take_ext;
        push_cnt   = push_en ? CNT_W'(npush) : '0;
        head_next  = head_reg + PTR_W'(ntake);
        tail_next  = tail_reg + PTR_W'(push_cnt);
        count_next = count_reg + push_cnt - ntake;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry contents need no reset; stale slots are never visible past count.
    always_ff @(posedge clock) begin
        if (push_en) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (fetch_vld_i[k]) begin
                    mem[tail_reg + PTR_W'(lane_off[k])] <= fetch_inst_i[k*INST_W +: INST_W];
`ifdef INSTQ_PC_EN
                    pc_mem[tail_reg + PTR_W'(lane_off[k])] <= fetch_pc_i + 64'(4*k);
`endif
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEC_W; gi++) begin : g_dec
            logic [PTR_W-1:0] rd_addr;
            assign rd_addr       = head_reg + PTR_W'(gi);
            assign dec_vld_o[gi] = (count_reg > CNT_W'(gi));
            assign dec_inst_o[gi*INST_W +: INST_W] = dec_vld_o[gi] ? mem[rd_addr] : '0;
`ifdef INSTQ_PC_EN
            assign dec_pc_o[gi*64 +: 64] = dec_vld_o[gi] ? pc_mem[rd_addr] : '0;
`endif
        end
    endgenerate

    assign count_o = count_reg;
    assign full_o  = (count_reg == CNT_W'(DEPTH));
    assign empty_o = (count_reg == '0);

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model predicts the post-edge state,
// and a negedge monitor pops and compares each prediction against the DUT.
module tb_inst_queue;

    localparam int INST_W  = 32;
    localparam int FETCH_W = 8;
    localparam int DEC_W   = 4;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int TAKE_W  = $clog2(DEC_W+1);

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      flush_i;
    logic [FETCH_W*INST_W-1:0] fetch_inst_i;
    logic [FETCH_W-1:0]        fetch_vld_i;
    logic                      fetch_rdy_o;
    logic [DEC_W*INST_W-1:0]   dec_inst_o;
    logic [DEC_W-1:0]          dec_vld_o;
    logic [TAKE_W-1:0]         dec_take_i;
    logic [CNT_W-1:0]          count_o;
    logic                      full_o;
    logic                      empty_o;
`ifdef INSTQ_PC_EN
    logic [63:0]               fetch_pc_i = 64'h0;
    logic [DEC_W*64-1:0]       dec_pc_o;
`endif

    always #5 clock = ~clock;

    inst_queue #(.INST_W(INST_W), .FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush_i),
        .fetch_inst_i(fetch_inst_i),
        .fetch_vld_i (fetch_vld_i),
        .fetch_rdy_o (fetch_rdy_o),
`ifdef INSTQ_PC_EN
        .fetch_pc_i  (fetch_pc_i),
        .dec_pc_o    (dec_pc_o),
`endif
        .dec_inst_o  (dec_inst_o),
        .dec_vld_o   (dec_vld_o),
        .dec_take_i  (dec_take_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    typedef struct {
        int                      count;
        bit                      rdy;
        bit                      full;
        bit                      empty;
        logic [DEC_W-1:0]        vld;
        logic [DEC_W*INST_W-1:0] insts;
    } snap_t;

    snap_t             exp_q[$];
    logic [INST_W-1:0] model_q[$];
    snap_t             mon_e;
    int                vectors     = 0;
    int                miscompares = 0;
    int                cyc         = 0;

    function automatic snap_t snapshot();
        snap_t s;
        s.count = model_q.size();
        s.rdy   = (DEPTH - s.count) >= FETCH_W;
        s.full  = (s.count == DEPTH);
        s.empty = (s.count == 0);
        s.vld   = '0;
        s.insts = '0;
        for (int j = 0; j < DEC_W; j++) begin
            if (j < s.count) begin
                s.vld[j] = 1'b1;
                s.insts[j*INST_W +: INST_W] = model_q[j];
            end
        end
        return s;
    endfunction

    task automatic cmp(input string name, input int lane, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s lane=%0d cyc=%0d got=%h exp=%h", name, lane, cyc, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp("count", 0, 64'(count_o), 64'(mon_e.count));
            cmp("fetch_rdy", 0, 64'(fetch_rdy_o), 64'(mon_e.rdy));
            cmp("full", 0, 64'(full_o), 64'(mon_e.full));
            cmp("empty", 0, 64'(empty_o), 64'(mon_e.empty));
            cmp("dec_vld", 0, 64'(dec_vld_o), 64'(mon_e.vld));
            for (int j = 0; j < DEC_W; j++)
                cmp("dec_inst", j, 64'(dec_inst_o[j*INST_W +: INST_W]),
                    64'(mon_e.insts[j*INST_W +: INST_W]));
        end
    end

    // Drive one cycle of stimulus, advance the model at the edge, queue the predicted state.
    task automatic step(input bit rst, input bit fl, input logic [FETCH_W-1:0] vld,
                        input int take, input logic [FETCH_W*INST_W-1:0] data);
        bit model_rdy;
        int ntake;
        reset        = rst;
        flush_i      = fl;
        fetch_vld_i  = vld;
        dec_take_i   = TAKE_W'(take);
        fetch_inst_i = data;
        model_rdy    = (DEPTH - model_q.size()) >= FETCH_W;
        @(posedge clock);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            ntake = (take > model_q.size()) ? model_q.size() : take;
            repeat (ntake) void'(model_q.pop_front());
            if (model_rdy)
                for (int k = 0; k < FETCH_W; k++)
                    if (vld[k]) model_q.push_back(data[k*INST_W +: INST_W]);
        end
        cyc++;
        #1;
        exp_q.push_back(snapshot());
    endtask

    function automatic logic [FETCH_W*INST_W-1:0] rand_data();
        logic [FETCH_W*INST_W-1:0] d;
        for (int k = 0; k < FETCH_W; k++) d[k*INST_W +: INST_W] = $urandom;
        return d;
    endfunction

    function automatic logic [FETCH_W*INST_W-1:0] seq_data(input logic [INST_W-1:0] base);
        logic [FETCH_W*INST_W-1:0] d;
        for (int k = 0; k < FETCH_W; k++) d[k*INST_W +: INST_W] = base + INST_W'(k);
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [FETCH_W-1:0] v;
        int                 t;
        bit                 r, f;
        reset = 1'b1; flush_i = 1'b0; fetch_vld_i = '0; dec_take_i = '0; fetch_inst_i = '0;

        step(1, 0, 8'h00, 0, '0);
        step(1, 0, 8'h00, 0, '0);
        // full group of sequential instructions
        step(0, 0, 8'hFF, 0, seq_data(32'h1000_0000));
        step(0, 0, 8'h00, 0, '0);
        // sparse group into an empty queue
        step(0, 1, 8'h00, 0, '0);
        step(0, 0, 8'b1010_0101, 0, seq_data(32'h2000_0000));
        step(0, 0, 8'h00, 0, '0);
        // fill to 9, blocked push, then single pop reopens
        step(0, 1, 8'h00, 0, '0);
        step(0, 0, 8'hFF, 0, seq_data(32'h3000_0000));
        step(0, 0, 8'h01, 0, seq_data(32'h3100_0000));
        step(0, 0, 8'hFF, 0, seq_data(32'h3200_0000));
        step(0, 0, 8'h00, 1, '0);
        // simultaneous push/pop, then run across the wrap point
        step(0, 1, 8'h00, 0, '0);
        step(0, 0, 8'hFF, 0, seq_data(32'h4000_0000));
        step(0, 0, 8'h00, 4, '0);
        step(0, 0, 8'hFF, 3, seq_data(32'h4100_0000));
        for (int i = 0; i < 24; i++)
            step(0, 0, 8'hFF, 4, seq_data(32'h4200_0000 + 32'(i*16)));
        // overrange take clamps to count
        step(0, 1, 8'h00, 0, '0);
        step(0, 0, 8'h03, 0, seq_data(32'h5000_0000));
        step(0, 0, 8'h00, 4, '0);
        step(0, 0, 8'h00, 7, '0);
        // flush beats a concurrent push and pop
        step(0, 1, 8'h00, 0, '0);
        step(0, 0, 8'h3F, 0, seq_data(32'h6000_0000));
        step(0, 1, 8'hFF, 2, seq_data(32'h6100_0000));
        step(0, 0, 8'h00, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = '1;
                default: v = FETCH_W'($urandom);
            endcase
            t = ((i / 200) % 2 == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
            step(r, f, v, t, rand_data());
        end

        reset = 1'b0; flush_i = 1'b0; fetch_vld_i = '0; dec_take_i = '0;
        @(negedge clock);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised successor to the fixed 8-in/4-out instruction buffer. Sits between fetch and the decoder array.
- Accepts up to FETCH_W instructions per cycle from fetch, with a sparse valid mask. Valid lanes are compacted in lane order into a circular queue.
- Presents the oldest DEC_W entries to the decoders each cycle.
- Decode may consume a variable number of entries per cycle (0..DEC_W), rather than all-or-nothing.

Parameters:
- INST_W, 32, instruction width in bits
- FETCH_W, 8, fetch lanes per cycle
- DEC_W, 4, decode lanes presented per cycle
- DEPTH, 16, queue entries; power of two, DEPTH >= FETCH_W + DEC_W

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries (redirect)
- fetch_inst_i  in  FETCH_W*INST_W  lane k at bits [k*INST_W +: INST_W]
- fetch_vld_i  in  FETCH_W  per-lane valid; any pattern allowed
- fetch_rdy_o  out  1  queue can accept a full fetch group this cycle
- dec_inst_o  out  DEC_W*INST_W  oldest entries; lane 0 = head
- dec_vld_o  out  DEC_W  thermometer-coded: lane j valid iff count > j
- dec_take_i  in  $clog2(DEC_W+1)  number of head entries consumed this cycle
- count_o  out  $clog2(DEPTH+1)  occupied entries
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0

Behaviour:
- Storage and pointers:
  - Entry array DEPTH x INST_W; head and tail pointers of width log2(DEPTH), wrapping naturally mod DEPTH.
  - count register of width $clog2(DEPTH+1).
- Reset (reset=1 at a clock edge): head=0, tail=0, count=0. Therefore fetch_rdy_o=1, empty_o=1, full_o=0, count_o=0, dec_vld_o=0, dec_inst_o=0. Entry contents are don't-care.
- fetch_rdy_o = (DEPTH - count) >= FETCH_W. This is combinational from count only and never depends on dec_take_i (no same-cycle pop-to-push path).
- Push (push_en = fetch_rdy_o & |fetch_vld_i):
  - npush = popcount(fetch_vld_i).
  - The i-th set lane (ascending lane index) is written to entry (tail + i) mod DEPTH.
  - tail advances by npush.
  - If fetch_rdy_o=0, the input is ignored; fetch must hold its group and retry.
- Pop: ntake = min(dec_take_i, count). An overrange request is clamped, never underflows. head advances by ntake.
- Next count = count + (push_en ? npush : 0) - ntake. Push and pop in the same cycle are both honoured.
- Output timing:
  - dec_inst_o lane j = entry (head + j) mod DEPTH when dec_vld_o[j]=1, else all zeros. Combinational from registered state.
  - Write-to-visible latency is 1 cycle; there is no same-cycle bypass from fetch to decode.
- full_o and empty_o are combinational from count.
- flush_i=1 at a clock edge: same effect as reset on head, tail and count. Flush has priority over a push and a pop in that cycle; the fetch group presented that cycle is dropped.
- reset has priority over flush_i.
- Wrap-around: a compacted push or a multi-entry pop that crosses entry DEPTH-1 continues at entry 0 with no bubble.

Optional Feature:
- Macro: INSTQ_PC_EN.
- When defined:
  - Adds fetch_pc_i (in, 64), the PC of fetch lane 0, and dec_pc_o (out, DEC_W*64).
  - Each entry also stores the PC of its source lane, computed as fetch_pc_i + 4*k for lane k.
  - dec_pc_o lanes follow the same valid and zeroing rules as dec_inst_o.
  - Reset and flush zero all dec_pc_o lanes.
- When undefined: these ports and the PC storage do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push fetch_vld_i=8'hFF with lane k = 32'h1000_0000+k.
  - Next cycle: count_o=8, dec_vld_o=4'hF, dec lanes = 0x10000000..0x10000003.
- Sparse push 8'b1010_0101 (lanes 0,2,5,7) into an empty queue.
  - Next cycle: count_o=4, decode lanes in order hold lane0, lane2, lane5, lane7 data.
- Fill to count=9 with dec_take_i=0.
  - fetch_rdy_o=0; a further push of 8'hFF is ignored and count stays 9.
  - Then dec_take_i=1 for one cycle: count=8, fetch_rdy_o=1.
- Simultaneous push of 8 and dec_take_i=3 at count=4 -> count=9. Run until the pointers cross entry 15 -> 0; all outputs remain in order with no loss.
- count=2 with dec_take_i=4 -> clamp: count=0, empty_o=1, dec_vld_o=0, dec_inst_o=0.
- flush_i together with a push of 8'hFF and dec_take_i=2 at count=6 -> next cycle count=0, empty_o=1, pushed data absent.
